// File: rtl/sha256_stream_padder.sv
// Streaming SHA-256 message padder: packs byte-aligned message words into 512-bit
// blocks and appends the 0x80 marker, zero fill and 64-bit bit-length field.
module sha256_stream_padder #(
    parameter int WORD_BITS  = 32,
    parameter int BLOCK_BITS = 512,
    parameter int LEN_BITS   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_BITS-1:0]          in_data,
    input  logic                          in_last,
    input  logic [$clog2(WORD_BITS/8):0]  in_bytes,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic [BLOCK_BITS-1:0]         blk_data,
    output logic                          blk_first,
    output logic                          blk_last
);

    localparam int unsigned WB      = WORD_BITS / 8;
    localparam int unsigned NW      = BLOCK_BITS / WORD_BITS;
    localparam int unsigned NB      = BLOCK_BITS / 8;
    localparam int unsigned IW      = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned BW      = $clog2(WB) + 1;
    localparam int unsigned LEN_POS = NB - LEN_BITS / 8;

    typedef enum logic [1:0] {
        FILL,
        OUT,
        LENBLK
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         idx;
    logic [LEN_BITS-1:0]   len_cnt;
    logic [LEN_BITS-1:0]   len_sum;
    logic [BW-1:0]         bytes_now;
    logic [BLOCK_BITS-1:0] blk;
    logic [BLOCK_BITS-1:0] last_blk;
    logic [BLOCK_BITS-1:0] len_blk;
    logic                  pend_len;
    logic                  pend_pad;
    int unsigned           data_start;
    int unsigned           pad_pos;

    assign blk_data = blk;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        blk_valid  = 1'b0;
        case (state)
            FILL: begin
                in_ready = rst_n;
                if (in_valid && (in_last || idx == IW'(NW - 1))) state_next = OUT;
            end
            OUT: begin
                blk_valid = 1'b1;
                if (blk_ready) state_next = pend_len ? LENBLK : FILL;
            end
            LENBLK: begin
                blk_valid = 1'b1;
                if (blk_ready) state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Final block image: earlier words kept, valid bytes of the last word, 0x80, zeros, length.
    always_comb begin
        bytes_now  = in_last ? in_bytes : BW'(WB);
        len_sum    = len_cnt + (LEN_BITS'(bytes_now) << 3);
        data_start = 32'(idx) * WB;
        pad_pos    = data_start + 32'(in_bytes);
        last_blk   = blk;
        for (int unsigned b = 0; b < NB; b++) begin
            if (b >= data_start) begin
                if (b < pad_pos)
                    last_blk[BLOCK_BITS-1-8*b -: 8] = in_data[WORD_BITS-1-8*((b - data_start) % WB) -: 8];
                else if (b == pad_pos)
                    last_blk[BLOCK_BITS-1-8*b -: 8] = 8'h80;
                else
                    last_blk[BLOCK_BITS-1-8*b -: 8] = 8'h00;
            end
        end
        if (pad_pos < LEN_POS) last_blk[LEN_BITS-1:0] = len_sum;

        len_blk                           = '0;
        len_blk[BLOCK_BITS-1 -: 8]        = pend_pad ? 8'h80 : 8'h00;
        len_blk[LEN_BITS-1:0]             = len_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            len_cnt   <= '0;
            blk       <= '0;
            blk_first <= 1'b1;
            blk_last  <= 1'b0;
            pend_len  <= 1'b0;
            pend_pad  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        len_cnt <= len_sum;
                        if (in_last) begin
                            blk      <= last_blk;
                            blk_last <= (pad_pos < LEN_POS);
                            pend_len <= (pad_pos >= LEN_POS);
                            pend_pad <= (pad_pos >= NB);
                        end else begin
                            blk[BLOCK_BITS-1-WORD_BITS*int'(idx) -: WORD_BITS] <= in_data;
                            blk_last <= 1'b0;
                            idx      <= idx + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_first <= 1'b0;
                        idx       <= '0;
                        if (pend_len) begin
                            // Spill-over: the length block reuses the output register.
                            blk      <= len_blk;
                            blk_last <= 1'b1;
                            pend_len <= 1'b0;
                        end else if (blk_last) begin
                            len_cnt   <= '0;
                            blk_first <= 1'b1;
                        end
                    end
                end
                LENBLK: begin
                    if (blk_ready) begin
                        idx       <= '0;
                        len_cnt   <= '0;
                        blk_first <= 1'b1;
                        pend_pad  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    a_in_bytes_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready && in_last) |-> (in_bytes <= BW'(WB)));

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder: directed spec cases plus random messages checked
// against a byte-level FIPS 180-4 padding model.
module tb_sha256_stream_padder;

    localparam int WORD_BITS  = 32;
    localparam int BLOCK_BITS = 512;
    localparam int LEN_BITS   = 64;
    localparam int WB         = WORD_BITS / 8;
    localparam int NW         = BLOCK_BITS / WORD_BITS;
    localparam int BW         = $clog2(WB) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WORD_BITS-1:0]  in_data = '0;
    logic                  in_last = 1'b0;
    logic [BW-1:0]         in_bytes = '0;
    logic                  blk_valid;
    logic                  blk_ready = 1'b0;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  blk_first;
    logic                  blk_last;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [BLOCK_BITS-1:0] data;
        logic                  first;
        logic                  last;
    } blk_t;

    logic [7:0]            msg[$];
    blk_t                  exp_q[$];
    logic [BLOCK_BITS-1:0] seen_data;
    logic [BLOCK_BITS-1:0] abc_blk;
    logic [BLOCK_BITS-1:0] empty_blk;

    sha256_stream_padder #(
        .WORD_BITS (WORD_BITS),
        .BLOCK_BITS(BLOCK_BITS),
        .LEN_BITS  (LEN_BITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_bytes (in_bytes),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data (blk_data),
        .blk_first(blk_first),
        .blk_last (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BLOCK_BITS-1:0] obs,
                         input logic [BLOCK_BITS-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: message || 0x80 || zeros to 56 mod 64 || 64-bit big-endian bit length.
    task automatic build_expected();
        logic [7:0]  pad[$];
        logic [63:0] bitlen;
        blk_t        b;
        int          nblk;
        pad    = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pad.push_back(bitlen[8*i +: 8]);
        exp_q.delete();
        nblk = pad.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 64; j++) b.data[BLOCK_BITS-1-8*j -: 8] = pad[64*k+j];
            b.first = (k == 0);
            b.last  = (k == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_fill(input int n, input logic [7:0] val);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(val);
    endtask

    task automatic set_random(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    // Drives msg word by word with random valid/ready gaps; checks every block and ready/valid.
    task automatic run_msg(input int valid_pct, input int ready_pct);
        int nwords, w, nblk, cyc, wcnt, outstanding;
        bit acc, con;
        build_expected();
        nwords      = (msg.size() == 0) ? 1 : (msg.size() + WB - 1) / WB;
        w           = 0;
        nblk        = 0;
        cyc         = 0;
        wcnt        = 0;
        outstanding = 0;
        while ((w < nwords || nblk < exp_q.size()) && cyc < 4000) begin
            in_valid = (w < nwords) && ($urandom_range(99) < valid_pct);
            in_last  = (w == nwords - 1);
            for (int j = 0; j < WB; j++) begin
                int bi;
                bi = w * WB + j;
                in_data[WORD_BITS-1-8*j -: 8] = (bi < msg.size()) ? msg[bi] : 8'($urandom);
            end
            in_bytes  = in_last ? BW'(msg.size() - w * WB) : BW'($urandom);
            blk_ready = ($urandom_range(99) < ready_pct);
            #1;
            check("in_ready", in_ready, outstanding == 0);
            check("blk_valid", blk_valid, outstanding != 0);
            acc = in_valid && (outstanding == 0);
            con = blk_ready && (outstanding != 0);
            if (con) begin
                if (nblk < exp_q.size()) begin
                    check("blk_data", blk_data, exp_q[nblk].data);
                    check("blk_first", blk_first, exp_q[nblk].first);
                    check("blk_last", blk_last, exp_q[nblk].last);
                end else begin
                    check("extra_block", 1'b1, 1'b0);
                end
                seen_data = blk_data;
                nblk++;
                outstanding--;
            end
            if (acc) begin
                if (in_last) outstanding = exp_q.size() - nblk;
                else if (wcnt == NW - 1) outstanding = 1;
                wcnt = in_last ? 0 : (wcnt + 1) % NW;
                w++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("msg_timeout", cyc < 4000, 1'b1);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
    endtask

    initial begin
        abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
        empty_blk = {32'h80000000, 480'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_blk_valid", blk_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_first", blk_first, 1'b1);
        check("rst_last", blk_last, 1'b0);
        check("rst_data", blk_data, '0);
        check("post_rst_ready", in_ready, 1'b1);

        // "abc" and empty message
        set_abc();
        run_msg(100, 100);
        check("abc_const", seen_data, abc_blk);
        msg.delete();
        run_msg(100, 100);
        check("empty_const", seen_data, empty_blk);

        // Length-field boundaries
        set_fill(55, 8'h41);
        run_msg(100, 100);
        check("n55_len", seen_data[63:0], 64'h1B8);
        set_fill(56, 8'h41);
        run_msg(100, 100);
        check("n56_len", seen_data[63:0], 64'h1C0);
        set_fill(64, 8'h41);
        run_msg(100, 100);
        check("n64_word0", seen_data[511:480], 32'h80000000);
        check("n64_len", seen_data[63:0], 64'h200);
        set_abc();
        run_msg(100, 100);
        check("abc_again", seen_data, abc_blk);

        // Backpressure: block held for 10 cycles, then one handshake
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'h616263A5;
        in_bytes = BW'(3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", blk_valid, 1'b1);
            check("bp_ready", in_ready, 1'b0);
            check("bp_data", blk_data, abc_blk);
            check("bp_flags", {blk_first, blk_last}, 2'b11);
            @(posedge clk);
            #1;
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("bp_one_hs", blk_valid, 1'b0);
            check("bp_resume", in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        blk_ready = 1'b0;

        // Reset mid-message after 7 words
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_data = 32'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ready", in_ready, 1'b0);
        rst_n     = 1'b1;
        blk_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("mid_rst_noblk", blk_valid, 1'b0);
        end
        blk_ready = 1'b0;
        set_abc();
        run_msg(100, 100);
        check("abc_after_rst", seen_data, abc_blk);

        // Random messages with random gaps and backpressure
        for (int m = 0; m < 30; m++) begin
            set_random($urandom_range(200));
            run_msg(70, 60);
        end
        for (int n = 119; n <= 129; n++) begin
            set_random(n);
            run_msg(80, 50);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
